// File: rtl/axi_master_pkg.sv
// Shared types for the AXI4-Lite control-port initiator.
// State encoding, AXI response codes and the command/response record layouts
// at the default geometry (8-bit address, 32-bit data).
package axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP,
        DRAIN
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_W-1:0]     addr;
        logic [DEF_DATA_W-1:0]     wdata;
        logic [DEF_DATA_W/8-1:0]   wstrb;
    } cmd_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]     rdata;
        logic [1:0]                resp;
        logic                      timeout;
    } rsp_t;

endpackage

// File: rtl/axi_lite_ctrl_master.sv
// AXI4-Lite initiator for one tile's control slave port.
// One command in flight; every command yields exactly one response.
// Optional feature: define AXI_MASTER_TIMEOUT_EN to add a response timeout
// (synthesized SLVERR response, then a DRAIN state that swallows the late B/R).
module axi_lite_ctrl_master
    import axi_master_pkg::*;
#(
    parameter int AXI_ADDR       = 8,
    parameter int BW_AXI         = 32,
    parameter int BWB_AXI        = BW_AXI / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_control,
    input  logic                clk_control_rst_low,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AXI_ADDR-1:0] cmd_addr,
    input  logic [BW_AXI-1:0]   cmd_wdata,
    input  logic [BWB_AXI-1:0]  cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [BW_AXI-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic [AXI_ADDR-1:0] control_M_AXI_AWADDR,
    output logic                control_M_AXI_AWVALID,
    input  logic                control_M_AXI_AWREADY,
    output logic [BW_AXI-1:0]   control_M_AXI_WDATA,
    output logic [BWB_AXI-1:0]  control_M_AXI_WSTRB,
    output logic                control_M_AXI_WVALID,
    input  logic                control_M_AXI_WREADY,
    input  logic [1:0]          control_M_AXI_BRESP,
    input  logic                control_M_AXI_BVALID,
    output logic                control_M_AXI_BREADY,
    output logic [AXI_ADDR-1:0] control_M_AXI_ARADDR,
    output logic                control_M_AXI_ARVALID,
    input  logic                control_M_AXI_ARREADY,
    input  logic [BW_AXI-1:0]   control_M_AXI_RDATA,
    input  logic [1:0]          control_M_AXI_RRESP,
    input  logic                control_M_AXI_RVALID,
    output logic                control_M_AXI_RREADY
);

    // A zero or negative timeout would make the counter compare meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_reg,      state_next;
    logic [AXI_ADDR-1:0]   addr_reg,       addr_next;
    logic [BW_AXI-1:0]     wdata_reg,      wdata_next;
    logic [BWB_AXI-1:0]    wstrb_reg,      wstrb_next;
    logic                  awvalid_reg,    awvalid_next;
    logic                  wvalid_reg,     wvalid_next;
    logic                  bready_reg,     bready_next;
    logic                  arvalid_reg,    arvalid_next;
    logic                  rready_reg,     rready_next;
    logic                  cmd_ready_reg,  cmd_ready_next;
    logic                  rsp_valid_reg,  rsp_valid_next;
    logic [BW_AXI-1:0]     rsp_rdata_reg,  rsp_rdata_next;
    logic [1:0]            rsp_resp_reg,   rsp_resp_next;
    logic                  aw_ok;
    logic                  w_ok;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0]    timer_reg,       timer_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;
    logic                  wr_reg,          wr_next;
`endif

    // A write channel is finished once its VALID has been dropped, or it handshakes now.
    assign aw_ok = !awvalid_reg || control_M_AXI_AWREADY;
    assign w_ok  = !wvalid_reg  || control_M_AXI_WREADY;

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        cmd_ready_next = cmd_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;
`ifdef AXI_MASTER_TIMEOUT_EN
        timer_next       = timer_reg;
        rsp_timeout_next = rsp_timeout_reg;
        wr_next          = wr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    addr_next      = cmd_addr;
`ifdef AXI_MASTER_TIMEOUT_EN
                    wr_next        = cmd_write;
`endif
                    if (cmd_write) begin
                        wdata_next   = cmd_wdata;
                        wstrb_next   = cmd_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_REQ;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_reg && control_M_AXI_AWREADY) awvalid_next = 1'b0;
                if (wvalid_reg && control_M_AXI_WREADY)   wvalid_next  = 1'b0;
                if (aw_ok && w_ok) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (control_M_AXI_BVALID) begin
                    bready_next    = 1'b0;
                    rsp_resp_next  = control_M_AXI_BRESP;
                    rsp_rdata_next = '0;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
`ifdef AXI_MASTER_TIMEOUT_EN
                else if (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    bready_next      = 1'b0;
                    rsp_resp_next    = RESP_SLVERR;
                    rsp_timeout_next = 1'b1;
                    rsp_rdata_next   = '0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RSP;
                end
`endif
            end
            RD_REQ: begin
                if (control_M_AXI_ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (control_M_AXI_RVALID) begin
                    rready_next    = 1'b0;
                    rsp_resp_next  = control_M_AXI_RRESP;
                    rsp_rdata_next = control_M_AXI_RDATA;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
`ifdef AXI_MASTER_TIMEOUT_EN
                else if (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    rready_next      = 1'b0;
                    rsp_resp_next    = RESP_SLVERR;
                    rsp_timeout_next = 1'b1;
                    rsp_rdata_next   = '0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RSP;
                end
`endif
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
                    rsp_timeout_next = 1'b0;
                    // The slave still owes a B/R beat; absorb it before taking new work.
                    if (rsp_timeout_reg) begin
                        bready_next = wr_reg;
                        rready_next = !wr_reg;
                        state_next  = DRAIN;
                    end else
`endif
                    begin
                        cmd_ready_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
            end
`ifdef AXI_MASTER_TIMEOUT_EN
            DRAIN: begin
                if ((control_M_AXI_BVALID && bready_reg) || (control_M_AXI_RVALID && rready_reg)) begin
                    bready_next    = 1'b0;
                    rready_next    = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
`ifdef AXI_MASTER_TIMEOUT_EN
        // Restart on every state change; count only while waiting on the slave, saturating.
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if ((state_reg == WR_REQ || state_reg == WR_RESP ||
                      state_reg == RD_REQ || state_reg == RD_RESP) &&
                     timer_reg != TIMER_W'(TIMEOUT_CYCLES)) begin
            timer_next = timer_reg + TIMER_W'(1);
        end
`endif
    end

    // State and output register bank; reset leaves only cmd_ready set.
    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
            timer_reg       <= '0;
            rsp_timeout_reg <= 1'b0;
            wr_reg          <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
`ifdef AXI_MASTER_TIMEOUT_EN
            timer_reg       <= timer_next;
            rsp_timeout_reg <= rsp_timeout_next;
            wr_reg          <= wr_next;
`endif
        end
    end

    assign cmd_ready             = cmd_ready_reg;
    assign rsp_valid             = rsp_valid_reg;
    assign rsp_rdata             = rsp_rdata_reg;
    assign rsp_resp              = rsp_resp_reg;
    assign control_M_AXI_AWADDR  = addr_reg;
    assign control_M_AXI_AWVALID = awvalid_reg;
    assign control_M_AXI_WDATA   = wdata_reg;
    assign control_M_AXI_WSTRB   = wstrb_reg;
    assign control_M_AXI_WVALID  = wvalid_reg;
    assign control_M_AXI_BREADY  = bready_reg;
    assign control_M_AXI_ARADDR  = addr_reg;
    assign control_M_AXI_ARVALID = arvalid_reg;
    assign control_M_AXI_RREADY  = rready_reg;
`ifdef AXI_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_reg;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_ctrl_master.sv
// Directed bench for axi_lite_ctrl_master with a configurable-latency AXI slave model.
// The timeout scenario is compiled in only when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_ctrl_master;
    import axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    // Slave model knobs and bookkeeping
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit          b_hold = 1'b0;
    logic [1:0]  resp_val = 2'b00;
    logic [31:0] rdata_val = '0;
    int          b_count = 0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          txn = 0;

    axi_lite_ctrl_master #(
        .AXI_ADDR(8), .BW_AXI(32), .BWB_AXI(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_control(clk),
        .clk_control_rst_low(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .control_M_AXI_AWADDR(awaddr),
        .control_M_AXI_AWVALID(awvalid),
        .control_M_AXI_AWREADY(awready),
        .control_M_AXI_WDATA(wdata),
        .control_M_AXI_WSTRB(wstrb),
        .control_M_AXI_WVALID(wvalid),
        .control_M_AXI_WREADY(wready),
        .control_M_AXI_BRESP(bresp),
        .control_M_AXI_BVALID(bvalid),
        .control_M_AXI_BREADY(bready),
        .control_M_AXI_ARADDR(araddr),
        .control_M_AXI_ARVALID(arvalid),
        .control_M_AXI_ARREADY(arready),
        .control_M_AXI_RDATA(rdata),
        .control_M_AXI_RRESP(rresp),
        .control_M_AXI_RVALID(rvalid),
        .control_M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave: updates at the falling edge; a handshake seen here completes at the next rising edge.
    initial begin : slave
        int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit  aw_got, w_got, ar_got;
        bit  aw_fire, w_fire, ar_fire, b_fire, r_fire;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
            end else begin
                if (aw_fire) aw_got = 1;
                if (w_fire)  w_got  = 1;
                if (ar_fire) ar_got = 1;
                if (b_fire) begin bvalid = 0; b_count++; end
                if (r_fire) rvalid = 0;
                if (awvalid) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
                else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt >= w_wait); w_cnt++; end
                else begin wready = 0; w_cnt = 0; end
                if (arvalid) begin arready = (ar_cnt >= ar_wait); ar_cnt++; end
                else begin arready = 0; ar_cnt = 0; end
                if (aw_got && w_got && !bvalid) begin
                    if (!b_hold && b_cnt >= b_wait) begin
                        bvalid = 1; bresp = resp_val; aw_got = 0; w_got = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (ar_got && !rvalid) begin
                    if (r_cnt >= r_wait) begin
                        rvalid = 1; rresp = resp_val; rdata = rdata_val; ar_got = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                aw_fire = awvalid && awready;
                w_fire  = wvalid && wready;
                ar_fire = arvalid && arready;
                b_fire  = bvalid && bready;
                r_fire  = rvalid && rready;
            end
        end
    end

    task automatic send_cmd(input cmd_t c);
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_wstrb = c.wstrb;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_rsp(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < limit);
        expect_eq({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic pop_rsp();
        txn++;
        $display("txn %0d: resp=%0d rdata=0x%08h timeout=%0d", txn, rsp_resp, rsp_rdata, rsp_timeout);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin : stim
        int   n;
        cmd_t c;
        logic [31:0] held_rdata;

        repeat (3) @(negedge clk);
        expect_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        expect_eq("rst_awvalid",   32'(awvalid),   32'd0);
        expect_eq("rst_arvalid",   32'(arvalid),   32'd0);
        expect_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: zero-wait write
        c = '{write: 1'b1, addr: 8'h04, wdata: 32'h0000_0012, wstrb: 4'hF};
        send_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        expect_eq("w1_awvalid@1", 32'(awvalid),  32'd1);
        expect_eq("w1_wvalid@1",  32'(wvalid),   32'd1);
        expect_eq("w1_awaddr",    32'(awaddr),   32'h04);
        expect_eq("w1_wdata",     wdata,         32'h12);
        expect_eq("w1_wstrb",     32'(wstrb),    32'hF);
        expect_eq("w1_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        expect_eq("w1_bready@2",  32'(bready),   32'd1);
        expect_eq("w1_awvalid@2", 32'(awvalid),  32'd0);
        @(negedge clk);
        expect_eq("w1_rsp_valid@3", 32'(rsp_valid), 32'd1);
        expect_eq("w1_resp",        32'(rsp_resp),  32'd0);
        expect_eq("w1_rdata",       rsp_rdata,      32'd0);
        expect_eq("w1_timeout",     32'(rsp_timeout), 32'd0);
        pop_rsp();
        expect_eq("w1_rsp_cleared", 32'(rsp_valid), 32'd0);
        expect_eq("w1_idle_ready",  32'(cmd_ready), 32'd1);

        // 2: AWREADY three cycles late, WREADY immediate, DECERR from the slave
        aw_wait = 3; resp_val = RESP_DECERR;
        c = '{write: 1'b1, addr: 8'h10, wdata: 32'hA5A5_0001, wstrb: 4'h3};
        send_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        expect_eq("w2_wvalid@1", 32'(wvalid), 32'd1);
        @(negedge clk);
        expect_eq("w2_wvalid@2",  32'(wvalid),  32'd0);
        expect_eq("w2_awvalid@2", 32'(awvalid), 32'd1);
        expect_eq("w2_bready@2",  32'(bready),  32'd0);
        @(negedge clk);
        @(negedge clk);
        expect_eq("w2_awvalid@4", 32'(awvalid), 32'd1);
        expect_eq("w2_awaddr@4",  32'(awaddr),  32'h10);
        expect_eq("w2_bready@4",  32'(bready),  32'd0);
        @(negedge clk);
        expect_eq("w2_awvalid@5", 32'(awvalid), 32'd0);
        expect_eq("w2_bready@5",  32'(bready),  32'd1);
        @(negedge clk);
        expect_eq("w2_rsp_valid@6", 32'(rsp_valid), 32'd1);
        expect_eq("w2_resp",        32'(rsp_resp),  32'(RESP_DECERR));
        pop_rsp();
        expect_eq("w2_b_count", 32'(b_count), 32'd2);
        aw_wait = 0; resp_val = RESP_OKAY;

        // 3: read with two slave wait cycles
        r_wait = 2; rdata_val = 32'hDEAD_BEEF;
        c = '{write: 1'b0, addr: 8'h08, wdata: 32'h0, wstrb: 4'h0};
        send_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        expect_eq("r3_arvalid@1", 32'(arvalid), 32'd1);
        expect_eq("r3_araddr",    32'(araddr),  32'h08);
        wait_rsp("r3", 20, n);
        expect_eq("r3_latency", 32'(n + 1), 32'd5);
        expect_eq("r3_rdata",   rsp_rdata,  32'hDEAD_BEEF);
        expect_eq("r3_resp",    32'(rsp_resp), 32'd0);
        pop_rsp();
        r_wait = 0;

        // 4: W late, AW first
        w_wait = 2;
        c = '{write: 1'b1, addr: 8'h18, wdata: 32'h0000_00FF, wstrb: 4'h1};
        send_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("w4", 20, n);
        expect_eq("w4_latency", 32'(n + 1), 32'd5);
        expect_eq("w4_resp",    32'(rsp_resp), 32'd0);
        pop_rsp();
        w_wait = 0;

        // 5: SLVERR read, response back-pressured while a second command waits
        resp_val = RESP_SLVERR; rdata_val = 32'h1234_5678;
        c = '{write: 1'b0, addr: 8'h0C, wdata: 32'h0, wstrb: 4'h0};
        send_cmd(c);
        @(negedge clk);
        c = '{write: 1'b1, addr: 8'h20, wdata: 32'h0BAD_F00D, wstrb: 4'h0};
        send_cmd(c);
        expect_eq("b5_busy_ready", 32'(cmd_ready), 32'd0);
        wait_rsp("b5", 20, n);
        expect_eq("b5_resp",  32'(rsp_resp), 32'(RESP_SLVERR));
        expect_eq("b5_rdata", rsp_rdata,     32'h1234_5678);
        held_rdata = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_eq($sformatf("b5_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
            expect_eq($sformatf("b5_hold_rdata%0d", i), rsp_rdata,      held_rdata);
            expect_eq($sformatf("b5_hold_ready%0d", i), 32'(cmd_ready), 32'd0);
        end
        pop_rsp();
        resp_val = RESP_OKAY;
        expect_eq("b5_ready_after", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        expect_eq("b5_second_aw",    32'(awvalid), 32'd1);
        expect_eq("b5_second_addr",  32'(awaddr),  32'h20);
        expect_eq("b5_second_wdata", wdata,        32'h0BAD_F00D);
        expect_eq("b5_second_wstrb", 32'(wstrb),   32'h0);
        wait_rsp("b5b", 20, n);
        expect_eq("b5b_resp",  32'(rsp_resp), 32'd0);
        expect_eq("b5b_rdata", rsp_rdata,     32'd0);
        pop_rsp();

`ifdef AXI_MASTER_TIMEOUT_EN
        // 6: slave withholds B; timeout after 16 cycles in WR_RESP, then drain
        b_hold = 1'b1;
        begin : timeout_case
            int before;
            before = b_count;
            c = '{write: 1'b1, addr: 8'h24, wdata: 32'h0000_0077, wstrb: 4'hF};
            send_cmd(c);
            @(negedge clk);
            cmd_valid = 1'b0;
            wait_rsp("t6", 40, n);
            expect_eq("t6_latency", 32'(n + 1), 32'd18);
            expect_eq("t6_resp",    32'(rsp_resp), 32'd2);
            expect_eq("t6_timeout", 32'(rsp_timeout), 32'd1);
            expect_eq("t6_rdata",   rsp_rdata, 32'd0);
            pop_rsp();
            expect_eq("t6_drain_bready", 32'(bready),    32'd1);
            expect_eq("t6_drain_ready",  32'(cmd_ready), 32'd0);
            b_hold = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!cmd_ready && n < 10);
            expect_eq("t6_idle_ready", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            expect_eq("t6_late_b_taken", 32'(b_count - before), 32'd1);
        end
`else
        expect_eq("timeout_tied_low", 32'(rsp_timeout), 32'd0);
`endif

        // 7: reset asserted while ARVALID is high
        ar_wait = 10;
        c = '{write: 1'b0, addr: 8'h30, wdata: 32'h0, wstrb: 4'h0};
        send_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        expect_eq("r7_arvalid_pre", 32'(arvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        expect_eq("r7_arvalid_rst", 32'(arvalid),   32'd0);
        expect_eq("r7_araddr_rst",  32'(araddr),    32'd0);
        expect_eq("r7_rdata_rst",   rsp_rdata,      32'd0);
        expect_eq("r7_rready_rst",  32'(rready),    32'd0);
        expect_eq("r7_cmd_rdy_rst", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ar_wait = 0; rdata_val = 32'h0000_00A5;
        @(negedge clk);
        expect_eq("r7_ready_after", 32'(cmd_ready), 32'd1);
        c = '{write: 1'b0, addr: 8'h14, wdata: 32'h0, wstrb: 4'h0};
        send_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("r7", 20, n);
        expect_eq("r7_latency", 32'(n + 1), 32'd3);
        expect_eq("r7_rdata",   rsp_rdata,  32'h0000_00A5);
        expect_eq("r7_resp",    32'(rsp_resp), 32'd0);
        pop_rsp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
